// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions (FSM state encoding, data width,
//                default bit period) used by the receiver and transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Serial frame state machine encoding, shared by RX and TX
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Payload bits per frame (8N1)
  localparam int DATA_BITS = 8;

  // 100 MHz system clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : rx_sync
//  Description : Two-flop synchronizer for the asynchronous serial line.
//                Both stages reset to 1 so the line reads idle out of reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  // Next-state: shift the raw line through the two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, idle-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : rx_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with mid-bit sampling, a single holding
//                register with valid/ack handshake, frame-error and overrun
//                pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  // Counter terminal values: half period for the start bit, full period after
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e           state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [IDX_W-1:0]      bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0]  shift_q,     shift_d;
  logic                  rx_prev_q,   rx_prev_d;
  logic                  cmpl_ok_q,   cmpl_ok_d;
  logic                  cmpl_bad_q,  cmpl_bad_d;
  logic [DATA_BITS-1:0]  rx_data_q,   rx_data_d;
  logic                  rx_valid_q,  rx_valid_d;
  logic                  rx_busy_q,   rx_busy_d;
  logic                  rx_ferr_q,   rx_ferr_d;
  logic                  rx_ovr_q,    rx_ovr_d;

  rx_sync u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Next-state logic: frame FSM, baud counter, shifter and output holding stage
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_prev_d  = rx_s;
    cmpl_ok_d  = 1'b0;
    cmpl_bad_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ferr_d  = 1'b0;
    rx_ovr_d   = 1'b0;

    if (!en) begin
      // Disabled: drop any partial frame and pending completion, keep rx_data
      state_d    = ST_IDLE;
      cnt_d      = '0;
      bit_idx_d  = '0;
      rx_valid_d = 1'b0;
    end else begin
      // Completion is applied one edge after the stop-bit sample
      if (cmpl_ok_q) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
        rx_ovr_d   = rx_valid_q & ~rx_ack;
      end else if (rx_valid_q && rx_ack) begin
        rx_valid_d = 1'b0;
      end
      rx_ferr_d = cmpl_bad_q;

      case (state_q)
        ST_IDLE: begin
          cnt_d     = '0;
          bit_idx_d = '0;
          if (rx_prev_q && !rx_s) begin
            state_d = ST_START;
          end
        end

        ST_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_d = '0;
            // A line already back high at mid start bit is a glitch
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == LAST_IDX) begin
              bit_idx_d = '0;
              state_d   = ST_STOP;
            end else begin
              bit_idx_d = bit_idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_d      = '0;
            state_d    = ST_IDLE;
            cmpl_ok_d  = rx_s;
            cmpl_bad_d = ~rx_s;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    rx_busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_prev_q  <= 1'b1;
      cmpl_ok_q  <= 1'b0;
      cmpl_bad_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_busy_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_prev_q  <= rx_prev_d;
      cmpl_ok_q  <= cmpl_ok_d;
      cmpl_bad_q <= cmpl_bad_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_busy_q  <= rx_busy_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_busy      = rx_busy_q;
  assign rx_frame_err = rx_ferr_q;
  assign rx_overrun   = rx_ovr_q;

endmodule : uart_rx
`default_nettype wire
